// File: rtl/char_seq_pkg.sv
// ----------------------------------------------------------------------------
// char_seq_pkg
// Shared definitions for the character stream sequencer: cpu_en encodings,
// the sequencer state enum, default block geometry and a helper that maps a
// sequencer state onto the cpu_en code presented to the processor.
// ----------------------------------------------------------------------------
package char_seq_pkg;

    // cpu_en encodings seen by the processor top level
    localparam logic [1:0] CPU_IDLE  = 2'b00;
    localparam logic [1:0] CPU_WRITE = 2'b01;
    localparam logic [1:0] CPU_EXEC  = 2'b10;

    // 12 rows x 9 characters per ciphertext block
    localparam int BUF_LEN_DEFAULT  = 108;
    localparam int EXEC_MAX_DEFAULT = 5000;

    typedef enum logic [2:0] {
        ST_FILL,
        ST_FULL,
        ST_WRITE,
        ST_EXEC,
        ST_DONE
    } seq_state_e;

    function automatic logic [1:0] cpu_en_of(input seq_state_e s);
        case (s)
            ST_WRITE: return CPU_WRITE;
            ST_EXEC:  return CPU_EXEC;
            default:  return CPU_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/char_buffer_ram.sv
// ----------------------------------------------------------------------------
// char_buffer_ram
// BUF_LEN x 8 character store: one synchronous write port, one asynchronous
// read port. The array carries no reset; validity of each entry is tracked by
// the sequencer's fill count.
//
// Ports
//   clk_i     in   clock
//   we_i      in   write enable
//   waddr_i   in   write address
//   wdata_i   in   write data
//   raddr_i   in   read address
//   rdata_o   out  read data (combinational)
// ----------------------------------------------------------------------------
module char_buffer_ram #(
    parameter int BUF_LEN = 108,
    parameter int AW      = $clog2(BUF_LEN + 1)
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [7:0]    wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [7:0]    rdata_o
);

    logic [7:0] mem_q [BUF_LEN];

    // Address guard keeps an out-of-range write from touching the array
    always_ff @(posedge clk_i) begin
        if (we_i && (waddr_i < AW'(BUF_LEN))) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/char_stream_sequencer.sv
// ----------------------------------------------------------------------------
// char_stream_sequencer
// Collects one ciphertext block from the host over a valid/ready handshake,
// then streams it to the processor's data RAM (cpu_en = WRITE for exactly
// BUF_LEN cycles), then lets the processor run (cpu_en = EXEC) until it
// signals completion or the watchdog expires.
//
// Ports
//   clock             in   sole clock, posedge
//   reset             in   asynchronous, active-low
//   in_valid          in   host byte valid
//   in_data[7:0]      in   host byte
//   in_ready          out  sequencer accepts a byte this cycle
//   start             in   level: begin WRITE->EXEC (edge-sensitive in DONE)
//   cpu_done          in   single-cycle completion pulse from the processor
//   cpu_en[1:0]       out  00 IDLE, 01 WRITE, 10 EXEC (registered)
//   char_buffer_data  out  byte for the current WRITE cycle, 0 otherwise
//   fill_count        out  bytes accepted so far, 0..BUF_LEN
//   busy              out  in WRITE or EXEC
//   done              out  in DONE after a normal finish
//   timeout           out  in DONE after a watchdog expiry
// ----------------------------------------------------------------------------
module char_stream_sequencer
    import char_seq_pkg::*;
#(
    parameter int         BUF_LEN         = BUF_LEN_DEFAULT,
    parameter int         EXEC_MAX_CYCLES = EXEC_MAX_DEFAULT,
    parameter logic [7:0] PAD_CHAR        = 8'h00,
    localparam int        CW              = $clog2(BUF_LEN + 1),
    localparam int        WW              = $clog2(EXEC_MAX_CYCLES + 1)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          in_valid,
    input  logic [7:0]    in_data,
    output logic          in_ready,
    input  logic          start,
    input  logic          cpu_done,
    output logic [1:0]    cpu_en,
    output logic [7:0]    char_buffer_data,
    output logic [CW-1:0] fill_count,
    output logic          busy,
    output logic          done,
    output logic          timeout
);

    localparam logic [CW-1:0] FILL_MAX = CW'(BUF_LEN);
    localparam logic [CW-1:0] RD_LAST  = CW'(BUF_LEN - 1);
    localparam logic [WW-1:0] WD_MAX   = WW'(EXEC_MAX_CYCLES);
    localparam logic [WW-1:0] WD_LAST  = WW'(EXEC_MAX_CYCLES - 1);

    seq_state_e    state_q, state_d;
    logic [CW-1:0] fill_q, fill_d;
    logic [CW-1:0] rd_idx_q, rd_idx_d;
    logic [WW-1:0] wdog_q, wdog_d;
    logic [1:0]    cpu_en_q, cpu_en_d;
    logic          done_q, done_d;
    logic          timeout_q, timeout_d;
    logic          start_q;
    logic          accept;
    logic [7:0]    rd_data;

    // Zero-latency handshake: ready depends only on registered state
    assign in_ready = (state_q == ST_FILL) && (fill_q < FILL_MAX);
    assign accept   = in_ready && in_valid;

    char_buffer_ram #(
        .BUF_LEN (BUF_LEN),
        .AW      (CW)
    ) u_buf (
        .clk_i   (clock),
        .we_i    (accept),
        .waddr_i (fill_q),
        .wdata_i (in_data),
        .raddr_i (rd_idx_q),
        .rdata_o (rd_data)
    );

    always_comb begin
        state_d   = state_q;
        fill_d    = fill_q;
        rd_idx_d  = rd_idx_q;
        wdog_d    = wdog_q;
        done_d    = done_q;
        timeout_d = timeout_q;

        case (state_q)
            ST_FILL: begin
                if (accept) begin
                    fill_d = fill_q + CW'(1);
                end
                // A byte arriving with start is stored on the same edge
                if (start) begin
                    state_d  = ST_WRITE;
                    rd_idx_d = '0;
                end else if (accept && (fill_q == RD_LAST)) begin
                    state_d = ST_FULL;
                end
            end
            ST_FULL: begin
                if (start) begin
                    state_d  = ST_WRITE;
                    rd_idx_d = '0;
                end
            end
            ST_WRITE: begin
                if (rd_idx_q == RD_LAST) begin
                    state_d = ST_EXEC;
                    wdog_d  = '0;
                end else begin
                    rd_idx_d = rd_idx_q + CW'(1);
                end
            end
            ST_EXEC: begin
                if (wdog_q < WD_MAX) begin
                    wdog_d = wdog_q + WW'(1);
                end
                // Completion takes priority over a coincident expiry
                if (cpu_done) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end else if (wdog_q >= WD_LAST) begin
                    state_d   = ST_DONE;
                    timeout_d = 1'b1;
                end
            end
            ST_DONE: begin
                // Only a fresh 0->1 of start re-arms; a held level does not
                if (start && !start_q) begin
                    state_d   = ST_FILL;
                    fill_d    = '0;
                    done_d    = 1'b0;
                    timeout_d = 1'b0;
                end
            end
            default: begin
                state_d = ST_FILL;
            end
        endcase

        cpu_en_d = cpu_en_of(state_d);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_FILL;
            fill_q    <= '0;
            rd_idx_q  <= '0;
            wdog_q    <= '0;
            cpu_en_q  <= CPU_IDLE;
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
            start_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            fill_q    <= fill_d;
            rd_idx_q  <= rd_idx_d;
            wdog_q    <= wdog_d;
            cpu_en_q  <= cpu_en_d;
            done_q    <= done_d;
            timeout_q <= timeout_d;
            start_q   <= start;
        end
    end

    // Positions never filled stream as padding
    assign char_buffer_data = (state_q != ST_WRITE) ? 8'h00 :
                              (rd_idx_q < fill_q)   ? rd_data : PAD_CHAR;
    assign cpu_en     = cpu_en_q;
    assign fill_count = fill_q;
    assign busy       = (state_q == ST_WRITE) || (state_q == ST_EXEC);
    assign done       = done_q;
    assign timeout    = timeout_q;

endmodule

// File: tb/tb_char_stream_sequencer.sv
module tb_char_stream_sequencer;

    localparam int BUF_LEN = 108;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       start = 1'b0;
    logic       cpu_done = 1'b0;

    logic       a_in_ready, a_busy, a_done, a_timeout;
    logic [1:0] a_cpu_en;
    logic [7:0] a_data;
    logic [6:0] a_fill;

    logic       w_in_ready, w_busy, w_done, w_timeout;
    logic [1:0] w_cpu_en;
    logic [7:0] w_data;
    logic [6:0] w_fill;

    always #5 clock = ~clock;

    // Default-parameter instance
    char_stream_sequencer dut (
        .clock            (clock),
        .reset            (reset),
        .in_valid         (in_valid),
        .in_data          (in_data),
        .in_ready         (a_in_ready),
        .start            (start),
        .cpu_done         (cpu_done),
        .cpu_en           (a_cpu_en),
        .char_buffer_data (a_data),
        .fill_count       (a_fill),
        .busy             (a_busy),
        .done             (a_done),
        .timeout          (a_timeout)
    );

    // Short-watchdog instance sharing the same stimulus
    char_stream_sequencer #(.EXEC_MAX_CYCLES(20)) dut_wd (
        .clock            (clock),
        .reset            (reset),
        .in_valid         (in_valid),
        .in_data          (in_data),
        .in_ready         (w_in_ready),
        .start            (start),
        .cpu_done         (cpu_done),
        .cpu_en           (w_cpu_en),
        .char_buffer_data (w_data),
        .fill_count       (w_fill),
        .busy             (w_busy),
        .done             (w_done),
        .timeout          (w_timeout)
    );

    int total = 0;
    int bad = 0;

    logic [7:0] model_q[$];
    logic [1:0] cap_en[BUF_LEN+1];
    logic [7:0] cap_d[BUF_LEN+1];

    function automatic logic [7:0] exp_byte(input int k);
        if (k < model_q.size()) return model_q[k];
        return 8'h00;
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        in_valid = 1'b0;
        start = 1'b0;
        cpu_done = 1'b0;
        in_data = 8'h00;
        #2;
        tick();
        reset = 1'b1;
        model_q.delete();
        tick();
    endtask

    // mode 0: 0x41+i, 1: 'A', 2: random. Returns at the first WRITE cycle.
    task automatic drive_load(input int n, input int mode, input bit gaps, input bit start_on_last);
        int sent = 0;
        model_q.delete();
        while (sent < n) begin
            in_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            if (mode == 0)      in_data = 8'(32'h41 + sent);
            else if (mode == 1) in_data = 8'h41;
            else                in_data = 8'($urandom);
            start = start_on_last && in_valid && (sent == n - 1);
            if (in_valid) begin
                model_q.push_back(in_data);
                sent++;
            end
            tick();
        end
        in_valid = 1'b0;
        if (!start_on_last) begin
            start = 1'b1;
            tick();
        end
        start = 1'b0;
    endtask

    // Records BUF_LEN WRITE cycles plus the following cycle; ends in EXEC cycle 0
    task automatic capture();
        for (int k = 0; k <= BUF_LEN; k++) begin
            cap_en[k] = a_cpu_en;
            cap_d[k]  = a_data;
            if (k != BUF_LEN) tick();
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        tick();
        tick();
        total++; if (a_cpu_en !== 2'b00) begin bad++; $display("FAIL reset_cpu_en: got %0h want 0", a_cpu_en); end
        total++; if (a_data !== 8'h00) begin bad++; $display("FAIL reset_data: got %0h want 0", a_data); end
        total++; if (a_fill !== 7'd0) begin bad++; $display("FAIL reset_fill: got %0d want 0", a_fill); end
        total++; if (a_in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got %0b want 1", a_in_ready); end
        total++; if ({a_busy, a_done, a_timeout} !== 3'b000) begin bad++; $display("FAIL reset_flags: got %0b want 000", {a_busy, a_done, a_timeout}); end
        reset = 1'b1;
        tick();
    endtask

    task automatic test_normal();
        apply_reset();
        drive_load(BUF_LEN, 0, 1'b0, 1'b0);
        capture();
        for (int k = 0; k < BUF_LEN; k++) begin
            total++;
            if (cap_en[k] !== 2'b01 || cap_d[k] !== 8'(32'h41 + k)) begin
                bad++;
                $display("FAIL normal_write[%0d]: got en=%0h d=%0h want en=1 d=%0h", k, cap_en[k], cap_d[k], 8'(32'h41 + k));
            end
        end
        total++; if (cap_en[BUF_LEN] !== 2'b10) begin bad++; $display("FAIL normal_exec_entry: got %0h want 2", cap_en[BUF_LEN]); end
        for (int c = 0; c < 50; c++) begin
            total++;
            if (a_cpu_en !== 2'b10 || a_busy !== 1'b1) begin bad++; $display("FAIL normal_exec[%0d]: got en=%0h busy=%0b want en=2 busy=1", c, a_cpu_en, a_busy); end
            tick();
        end
        cpu_done = 1'b1;
        tick();
        cpu_done = 1'b0;
        total++; if (a_cpu_en !== 2'b00) begin bad++; $display("FAIL normal_done_en: got %0h want 0", a_cpu_en); end
        total++; if ({a_done, a_timeout, a_busy} !== 3'b100) begin bad++; $display("FAIL normal_done_flags: got %0b want 100", {a_done, a_timeout, a_busy}); end
        total++; if (a_fill !== 7'd108) begin bad++; $display("FAIL normal_fill: got %0d want 108", a_fill); end
    endtask

    task automatic test_backpressure();
        bit exp_ready;
        apply_reset();
        for (int i = 0; i < BUF_LEN + 2; i++) begin
            in_valid = 1'b1;
            in_data = 8'(i + 1);
            exp_ready = (model_q.size() < BUF_LEN);
            total++;
            if (a_in_ready !== exp_ready || a_fill !== 7'(model_q.size())) begin
                bad++;
                $display("FAIL bp_ready[%0d]: got rdy=%0b fill=%0d want rdy=%0b fill=%0d", i, a_in_ready, a_fill, exp_ready, model_q.size());
            end
            if (exp_ready) model_q.push_back(in_data);
            tick();
        end
        in_valid = 1'b0;
        total++; if (a_fill !== 7'd108 || a_in_ready !== 1'b0) begin bad++; $display("FAIL bp_full: got fill=%0d rdy=%0b want 108 0", a_fill, a_in_ready); end
        start = 1'b1;
        tick();
        start = 1'b0;
        capture();
        for (int k = 0; k < BUF_LEN; k++) begin
            total++;
            if (cap_d[k] !== exp_byte(k)) begin bad++; $display("FAIL bp_stream[%0d]: got %0h want %0h", k, cap_d[k], exp_byte(k)); end
        end
    endtask

    task automatic test_partial();
        logic [7:0] exp;
        apply_reset();
        drive_load(10, 1, 1'b0, 1'b0);
        capture();
        for (int k = 0; k < BUF_LEN; k++) begin
            exp = (k < 10) ? 8'h41 : 8'h00;
            total++;
            if (cap_en[k] !== 2'b01 || cap_d[k] !== exp) begin bad++; $display("FAIL partial[%0d]: got en=%0h d=%0h want en=1 d=%0h", k, cap_en[k], cap_d[k], exp); end
        end
        total++; if (cap_en[BUF_LEN] !== 2'b10) begin bad++; $display("FAIL partial_len: got %0h want 2", cap_en[BUF_LEN]); end
    endtask

    task automatic test_random_load();
        int n;
        for (int it = 0; it < 4; it++) begin
            apply_reset();
            n = (it == 0) ? BUF_LEN : $urandom_range(1, BUF_LEN);
            drive_load(n, 2, 1'b1, 1'b1);
            capture();
            for (int k = 0; k < BUF_LEN; k++) begin
                total++;
                if (cap_en[k] !== 2'b01 || cap_d[k] !== exp_byte(k)) begin bad++; $display("FAIL rand%0d[%0d]: got en=%0h d=%0h want en=1 d=%0h", it, k, cap_en[k], cap_d[k], exp_byte(k)); end
            end
            total++; if (a_fill !== 7'(n) || cap_en[BUF_LEN] !== 2'b10) begin bad++; $display("FAIL rand%0d_end: got fill=%0d en=%0h want fill=%0d en=2", it, a_fill, cap_en[BUF_LEN], n); end
        end
    endtask

    task automatic test_watchdog();
        apply_reset();
        drive_load(5, 2, 1'b0, 1'b0);
        capture();
        for (int c = 0; c < 20; c++) begin
            total++;
            if (w_cpu_en !== 2'b10 || w_done !== 1'b0) begin bad++; $display("FAIL wd_exec[%0d]: got en=%0h done=%0b want en=2 done=0", c, w_cpu_en, w_done); end
            tick();
        end
        total++; if (w_cpu_en !== 2'b00) begin bad++; $display("FAIL wd_expire_en: got %0h want 0", w_cpu_en); end
        total++; if ({w_timeout, w_done} !== 2'b10) begin bad++; $display("FAIL wd_expire_flags: got %0b want 10", {w_timeout, w_done}); end
        total++; if (a_cpu_en !== 2'b10 || a_timeout !== 1'b0) begin bad++; $display("FAIL wd_long_still_exec: got en=%0h to=%0b want en=2 to=0", a_cpu_en, a_timeout); end

        apply_reset();
        drive_load(5, 2, 1'b0, 1'b0);
        capture();
        for (int c = 0; c < 19; c++) tick();
        cpu_done = 1'b1;
        tick();
        cpu_done = 1'b0;
        total++; if (w_cpu_en !== 2'b00) begin bad++; $display("FAIL wd_tie_en: got %0h want 0", w_cpu_en); end
        total++; if ({w_done, w_timeout} !== 2'b10) begin bad++; $display("FAIL wd_tie_flags: got %0b want 10", {w_done, w_timeout}); end
    endtask

    task automatic test_reset_mid_write();
        apply_reset();
        drive_load(BUF_LEN, 2, 1'b1, 1'b0);
        for (int k = 0; k < 40; k++) tick();
        total++; if (a_cpu_en !== 2'b01) begin bad++; $display("FAIL rmw_in_write: got %0h want 1", a_cpu_en); end
        #2;
        reset = 1'b0;
        #1;
        total++; if (a_cpu_en !== 2'b00) begin bad++; $display("FAIL rmw_cpu_en: got %0h want 0", a_cpu_en); end
        total++; if (a_fill !== 7'd0 || a_in_ready !== 1'b1) begin bad++; $display("FAIL rmw_fill_ready: got fill=%0d rdy=%0b want 0 1", a_fill, a_in_ready); end
        total++; if (a_data !== 8'h00 || a_busy !== 1'b0) begin bad++; $display("FAIL rmw_data_busy: got d=%0h busy=%0b want 0 0", a_data, a_busy); end
        tick();
        reset = 1'b1;
        tick();
        drive_load(BUF_LEN, 2, 1'b0, 1'b0);
        capture();
        for (int k = 0; k < BUF_LEN; k++) begin
            total++;
            if (cap_en[k] !== 2'b01 || cap_d[k] !== exp_byte(k)) begin bad++; $display("FAIL rmw_reload[%0d]: got en=%0h d=%0h want en=1 d=%0h", k, cap_en[k], cap_d[k], exp_byte(k)); end
        end
        total++; if (cap_en[BUF_LEN] !== 2'b10) begin bad++; $display("FAIL rmw_reload_len: got %0h want 2", cap_en[BUF_LEN]); end
    endtask

    task automatic test_restart();
        apply_reset();
        drive_load(20, 2, 1'b0, 1'b0);
        start = 1'b1;  // held high through WRITE, EXEC and into DONE
        capture();
        for (int k = 0; k < BUF_LEN; k++) begin
            total++;
            if (cap_en[k] !== 2'b01 || cap_d[k] !== exp_byte(k)) begin bad++; $display("FAIL rs_write[%0d]: got en=%0h d=%0h want en=1 d=%0h", k, cap_en[k], cap_d[k], exp_byte(k)); end
        end
        for (int c = 0; c < 3; c++) tick();
        cpu_done = 1'b1;
        tick();
        cpu_done = 1'b0;
        for (int c = 0; c < 5; c++) begin
            total++;
            if (a_done !== 1'b1 || a_cpu_en !== 2'b00 || a_fill !== 7'd20) begin bad++; $display("FAIL rs_held[%0d]: got done=%0b en=%0h fill=%0d want 1 0 20", c, a_done, a_cpu_en, a_fill); end
            tick();
        end
        start = 1'b0;
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        total++; if (a_fill !== 7'd0 || a_in_ready !== 1'b1) begin bad++; $display("FAIL rs_fill: got fill=%0d rdy=%0b want 0 1", a_fill, a_in_ready); end
        total++; if ({a_done, a_timeout, a_busy} !== 3'b000 || a_cpu_en !== 2'b00) begin bad++; $display("FAIL rs_flags: got %0b en=%0h want 000 en=0", {a_done, a_timeout, a_busy}, a_cpu_en); end
        tick();
        total++; if (a_in_ready !== 1'b1 || a_cpu_en !== 2'b00) begin bad++; $display("FAIL rs_stays_fill: got rdy=%0b en=%0h want 1 0", a_in_ready, a_cpu_en); end
        // Back-to-back block after the restart
        drive_load(BUF_LEN, 2, 1'b1, 1'b1);
        capture();
        for (int k = 0; k < BUF_LEN; k++) begin
            total++;
            if (cap_en[k] !== 2'b01 || cap_d[k] !== exp_byte(k)) begin bad++; $display("FAIL b2b[%0d]: got en=%0h d=%0h want en=1 d=%0h", k, cap_en[k], cap_d[k], exp_byte(k)); end
        end
        total++; if (cap_en[BUF_LEN] !== 2'b10) begin bad++; $display("FAIL b2b_len: got %0h want 2", cap_en[BUF_LEN]); end
    endtask

    initial begin
        test_reset();
        test_normal();
        test_backpressure();
        test_partial();
        test_random_load();
        test_watchdog();
        test_reset_mid_write();
        test_restart();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
